rst_seq_gen: RTL and testbench

- Parametrised successor to the board-level cold-start reset counter and toggle clock divider.
- Sequences N_CH independent active-high reset domains, e.g. core, MAC, PHY/GT, I2C. Releases are strictly ordered, and each domain waits for its own debounced ready input, e.g. PLL lock or SFP clock alarm deasserted.
- Re-asserts downstream resets on loss of ready and records sticky faults.
- Provides a parametrised clock-enable pulse that replaces fabric toggle dividers. Sits in the board top, fed directly by the system clock.

---
 rtl/rst_seq_gen_pkg.sv | 23 ++
 rtl/rst_seq_sync.sv | 26 ++
 rtl/rst_seq_gen.sv | 169 ++++++++++++++++
 tb/tb_rst_seq_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_gen_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rst_seq_gen_pkg;

    typedef enum logic [1:0] {
        COLD     = 2'd0,
        WAIT_RDY = 2'd1,
        GAP      = 2'd2,
        RUN      = 2'd3
    } state_t;

    // Width of a counter that has to reach (max period - 1) for any timed phase.
    function automatic int cnt_width(input int cold, input int deb, input int gap, input int div);
        int m;
        m = cold;
        if (deb > m) m = deb;
        if (gap > m) m = gap;
        if (div > m) m = div;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Two-flop synchroniser bank for asynchronous level inputs.
// Latency: 2 clock edges from input change to output.
// Backpressure: none; output follows input continuously.
module rst_seq_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture; both stages clear asynchronously so ready reads low in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rst_seq_gen.sv
// Ordered multi-domain reset release with per-domain debounced ready, fault capture and a clock-enable divider.
// Latency: domain i releases COLD_CYCLES + (i+1)*DEBOUNCE + i*STAGE_GAP edges after reset; loss of ready reacts 1 edge after sync.
// Backpressure: none; a domain whose ready is missing simply stalls the sequence at that stage.
module rst_seq_gen
    import rst_seq_gen_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int COLD_CYCLES = 16384,
    parameter int DEBOUNCE    = 256,
    parameter int STAGE_GAP   = 64,
    parameter int DIV         = 2
) (
    input  logic                       clk200,
    input  logic                       sys_rst_n,
    input  logic                       soft_rst,
    input  logic [N_CH-1:0]            ch_ready,
    output logic [N_CH-1:0]            rst_out,
    output logic                       seq_done,
    output logic [$clog2(N_CH+1)-1:0]  cur_stage,
    output logic [N_CH-1:0]            fault,
    output logic                       ce_div
);

    localparam int SW = $clog2(N_CH + 1);
    localparam int CW = cnt_width(COLD_CYCLES, DEBOUNCE, STAGE_GAP, DIV);

    localparam logic [CW-1:0] COLD_LAST = CW'(COLD_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   div_q;
    logic            ce_q;
    logic [SW-1:0]   stage_q, stage_d;
    logic [N_CH-1:0] rst_q, rst_d;
    logic [N_CH-1:0] fault_q, fault_d;
    logic [N_CH-1:0] ready_s;
    logic [N_CH-1:0] lost;
    logic            sel_rdy;
    logic            acc;

    rst_seq_sync #(.W(N_CH)) u_sync (
        .clk   (clk200),
        .rst_n (sys_rst_n),
        .d     (ch_ready),
        .q     (ready_s)
    );

    // A released domain (reset low) whose synchronised ready has dropped.
    assign lost = ~rst_q & ~ready_s;

    // Synchronised ready of the stage currently being waited on.
    always_comb begin
        sel_rdy = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (stage_q == SW'(i)) sel_rdy = ready_s[i];
        end
    end

    // Free-running divider; unaffected by soft_rst so downstream enables never stutter.
    always_ff @(posedge clk200 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + CW'(1);
            ce_q  <= (div_q == DIV_LAST);
        end
    end

    // Sequencer state register; async reset puts every domain back into reset immediately.
    always_ff @(posedge clk200 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= COLD;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            fault_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rst_q   <= rst_d;
            fault_q <= fault_d;
        end
    end

    // Next-state: soft_rst first, then loss of ready, then normal timed progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_d   = rst_q;
        fault_d = fault_q;
        acc     = 1'b0;
        if (soft_rst) begin
            state_d = COLD;
            cnt_d   = '0;
            stage_d = '0;
            rst_d   = '1;
            fault_d = '0;
        end else if ((state_q != COLD) && (|lost)) begin
            // Re-assert from the lowest lost domain upward so rst_out stays contiguous.
            fault_d = fault_q | lost;
            state_d = WAIT_RDY;
            cnt_d   = '0;
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (lost[i]) stage_d = SW'(i);
            end
            for (int i = 0; i < N_CH; i++) begin
                acc      = acc | lost[i];
                rst_d[i] = rst_q[i] | acc;
            end
        end else begin
            case (state_q)
                COLD: begin
                    if (cnt_q == COLD_LAST) begin
                        state_d = WAIT_RDY;
                        cnt_d   = '0;
                        stage_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_RDY: begin
                    if (!sel_rdy) begin
                        cnt_d = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        cnt_d = '0;
                        for (int i = 0; i < N_CH; i++) begin
                            if (stage_q == SW'(i)) rst_d[i] = 1'b0;
                        end
                        if (stage_q == SW'(N_CH - 1)) begin
                            state_d = RUN;
                            stage_d = SW'(N_CH);
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = WAIT_RDY;
                        cnt_d   = '0;
                        stage_d = stage_q + SW'(1);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are direct views of registered state, so they cannot glitch.
    always_comb begin
        rst_out   = rst_q;
        fault     = fault_q;
        cur_stage = stage_q;
        seq_done  = (state_q == RUN);
        ce_div    = ce_q;
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
module tb_rst_seq_gen;

    localparam int N_CH        = 3;
    localparam int COLD_CYCLES = 16;
    localparam int DEBOUNCE    = 4;
    localparam int STAGE_GAP   = 8;
    localparam int DIV         = 2;

    logic            clk200    = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            soft_rst  = 1'b0;
    logic [N_CH-1:0] ch_ready  = '1;
    logic [N_CH-1:0] rst_out;
    logic            seq_done;
    logic [1:0]      cur_stage;
    logic [N_CH-1:0] fault;
    logic            ce_div;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt;
    logic [7:0] pat;

    rst_seq_gen #(
        .N_CH        (N_CH),
        .COLD_CYCLES (COLD_CYCLES),
        .DEBOUNCE    (DEBOUNCE),
        .STAGE_GAP   (STAGE_GAP),
        .DIV         (DIV)
    ) dut (
        .clk200    (clk200),
        .sys_rst_n (sys_rst_n),
        .soft_rst  (soft_rst),
        .ch_ready  (ch_ready),
        .rst_out   (rst_out),
        .seq_done  (seq_done),
        .cur_stage (cur_stage),
        .fault     (fault),
        .ce_div    (ce_div)
    );

    always #5 clk200 = ~clk200;

    // Edge count since reset release, used to predict ce_div.
    always @(posedge clk200 or negedge sys_rst_n) begin
        if (!sys_rst_n) ecnt <= 0;
        else            ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk200);
        #1;
    endtask

    task automatic chk_ce(input string tag);
        chk(tag, {31'd0, ce_div}, {31'd0, (ecnt > 0) && (ecnt % DIV == 0)});
    endtask

    task automatic do_reset(input logic [N_CH-1:0] rdy);
        sys_rst_n = 1'b0;
        soft_rst  = 1'b0;
        ch_ready  = rdy;
        #12;
        @(negedge clk200);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        ch_ready = 3'b111;
        #12;
        chk("rst_rst_out",   {29'd0, rst_out},   32'h7);
        chk("rst_seq_done",  {31'd0, seq_done},  32'h0);
        chk("rst_cur_stage", {30'd0, cur_stage}, 32'h0);
        chk("rst_fault",     {29'd0, fault},     32'h0);
        chk("rst_ce_div",    {31'd0, ce_div},    32'h0);

        // Clean power-up: releases at edges 20 / 32 / 44
        @(negedge clk200);
        sys_rst_n = 1'b1;
        tick(1);  chk("ce_e1", {31'd0, ce_div}, 32'h0);
        tick(1);  chk("ce_e2", {31'd0, ce_div}, 32'h1);
        tick(17); chk("up_e19_rst", {29'd0, rst_out}, 32'h7);
        tick(1);  chk("up_e20_rst", {29'd0, rst_out}, 32'h6);
                  chk("up_e20_stage", {30'd0, cur_stage}, 32'h0);
        tick(11); chk("up_e31_rst", {29'd0, rst_out}, 32'h6);
                  chk("up_e31_stage", {30'd0, cur_stage}, 32'h1);
        tick(1);  chk("up_e32_rst", {29'd0, rst_out}, 32'h4);
        tick(11); chk("up_e43_rst", {29'd0, rst_out}, 32'h4);
                  chk("up_e43_done", {31'd0, seq_done}, 32'h0);
        tick(1);  chk("up_e44_rst", {29'd0, rst_out}, 32'h0);
                  chk("up_e44_done", {31'd0, seq_done}, 32'h1);
                  chk("up_e44_stage", {30'd0, cur_stage}, 32'h3);
                  chk("up_e44_fault", {29'd0, fault}, 32'h0);
                  chk_ce("up_e44_ce");

        // One-cycle loss of ch_ready[0] in RUN
        tick(3);
        ch_ready = 3'b110;
        tick(1);
        ch_ready = 3'b111;
        tick(1);  chk("drop_pre_rst", {29'd0, rst_out}, 32'h0);
        tick(1);  chk("drop_fault", {29'd0, fault}, 32'h1);
                  chk("drop_rst", {29'd0, rst_out}, 32'h7);
                  chk("drop_stage", {30'd0, cur_stage}, 32'h0);
                  chk("drop_done", {31'd0, seq_done}, 32'h0);
        tick(3);  chk("rerel0_pre", {29'd0, rst_out}, 32'h7);
        tick(1);  chk("rerel0", {29'd0, rst_out}, 32'h6);
        tick(11); chk("rerel1_pre", {29'd0, rst_out}, 32'h6);
        tick(1);  chk("rerel1", {29'd0, rst_out}, 32'h4);
        tick(11); chk("rerel2_pre", {29'd0, rst_out}, 32'h4);
        tick(1);  chk("rerel2", {29'd0, rst_out}, 32'h0);
                  chk("rerel_done", {31'd0, seq_done}, 32'h1);
                  chk("rerel_fault", {29'd0, fault}, 32'h1);

        // soft_rst pulse in RUN with a recorded fault
        tick(2);
        soft_rst = 1'b1;
        tick(1);
        soft_rst = 1'b0;
        chk("soft_fault", {29'd0, fault}, 32'h0);
        chk("soft_rst_out", {29'd0, rst_out}, 32'h7);
        chk("soft_done", {31'd0, seq_done}, 32'h0);
        chk("soft_stage", {30'd0, cur_stage}, 32'h0);
        tick(19); chk("soft_e19_rst", {29'd0, rst_out}, 32'h7);
                  chk_ce("soft_e19_ce");
        tick(1);  chk("soft_e20_rst", {29'd0, rst_out}, 32'h6);
                  chk_ce("soft_e20_ce");
        tick(11); chk("soft_e31_rst", {29'd0, rst_out}, 32'h6);
        tick(1);  chk("soft_e32_rst", {29'd0, rst_out}, 32'h4);
        tick(11); chk("soft_e43_rst", {29'd0, rst_out}, 32'h4);
        tick(1);  chk("soft_e44_rst", {29'd0, rst_out}, 32'h0);
                  chk("soft_e44_done", {31'd0, seq_done}, 32'h1);

        // Stall on ch_ready[1] until edge 60
        do_reset(3'b101);
        tick(20); chk("stall_e20_rst", {29'd0, rst_out}, 32'h6);
        tick(40); chk("stall_e60_rst", {29'd0, rst_out}, 32'h6);
                  chk("stall_e60_stage", {30'd0, cur_stage}, 32'h1);
                  chk("stall_e60_done", {31'd0, seq_done}, 32'h0);
        ch_ready = 3'b111;
        tick(5);  chk("stall_e65_rst", {29'd0, rst_out}, 32'h6);
        tick(1);  chk("stall_e66_rst", {29'd0, rst_out}, 32'h4);
        tick(11); chk("stall_e77_rst", {29'd0, rst_out}, 32'h4);
        tick(1);  chk("stall_e78_rst", {29'd0, rst_out}, 32'h0);
                  chk("stall_e78_done", {31'd0, seq_done}, 32'h1);

        // Debounce glitch on ch_ready[1]: raw 1,1,1,0,1,1,1,1 after edges 30..37
        do_reset(3'b101);
        pat = 8'b1111_0111;
        tick(30);
        for (int i = 0; i < 8; i++) begin
            ch_ready[1] = pat[i];
            tick(1);
            if (i == 5) chk("glitch_e36_rst", {29'd0, rst_out}, 32'h6);
        end
        tick(1);  chk("glitch_e39_rst", {29'd0, rst_out}, 32'h6);
        tick(1);  chk("glitch_e40_rst", {29'd0, rst_out}, 32'h4);

        // Asynchronous sys_rst_n mid-GAP, while ce_div is high
        tick(4);  chk_ce("arst_pre_ce");
                  chk("arst_pre_stage", {30'd0, cur_stage}, 32'h1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("arst_rst_out", {29'd0, rst_out}, 32'h7);
        chk("arst_done", {31'd0, seq_done}, 32'h0);
        chk("arst_stage", {30'd0, cur_stage}, 32'h0);
        chk("arst_fault", {29'd0, fault}, 32'h0);
        chk("arst_ce", {31'd0, ce_div}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
